// File: rtl/puf_ro_sequencer_if.sv
// Host/PUF-core signal bundle for puf_ro_sequencer.
// master = host plus the PUF core model; slave = the sequencer itself.
interface puf_ro_sequencer_if #(
    parameter int SIZE      = 8,
    parameter int RESP_BITS = 16
);
    logic                 start;
    logic                 abort;
    logic [SIZE-1:0]      seed;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] resp_word;
    logic                 puf_enable;
    logic [SIZE-1:0]      puf_challenge;
    logic                 puf_response;

    modport master (
        output start, abort, seed, puf_response,
        input  busy, done, resp_word, puf_enable, puf_challenge
    );
    modport slave (
        input  start, abort, seed, puf_response,
        output busy, done, resp_word, puf_enable, puf_challenge
    );
endinterface

// File: rtl/puf_ro_sequencer.sv
// RO-PUF measurement sequencer: one CLEAR/RUN/SETTLE/SAMPLE pass per challenge bit.
// Define PUF_RO_VOTE_EN for three passes per bit with majority vote.
module puf_ro_sequencer #(
    parameter int SIZE          = 8,
    parameter int RESP_BITS     = 16,
    parameter int WINDOW        = 1024,
    parameter int CLEAR_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    puf_ro_sequencer_if.slave   bus
);
    localparam int HALF = SIZE / 2;
    localparam int KW   = $clog2(RESP_BITS);
    localparam int MAX1 = (WINDOW > CLEAR_CYCLES) ? WINDOW : CLEAR_CYCLES;
    localparam int MAXC = (MAX1 > SETTLE_CYCLES) ? MAX1 : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [KW-1:0] K_LAST = KW'(RESP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] SAMPLE = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]      state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [KW-1:0]   k;
    logic [SIZE-1:0] seed_q;
    logic [1:0]      resp_sync;
    logic [HALF-1:0] lo, hi_raw, hi;
    logic            accept, bit_done, run_last;

    assign accept = (state == IDLE) && bus.start && !bus.abort;

    // Nibble arithmetic wraps mod 2^HALF; bump hi when it collides with lo
    assign lo     = seed_q[HALF-1:0] + HALF'(k);
    assign hi_raw = seed_q[SIZE-1:HALF] + HALF'(k) + HALF'({k, 1'b0});
    assign hi     = (hi_raw == lo) ? hi_raw + HALF'(1) : hi_raw;

`ifdef PUF_RO_VOTE_EN
    logic [1:0] vote, ones;
    assign bit_done = (vote == 2'd2);
`else
    assign bit_done = 1'b1;
`endif
    assign run_last = bit_done && (k == K_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CLEAR;
            CLEAR:   if (cnt == CW'(CLEAR_CYCLES - 1)) state_nxt = RUN;
            RUN:     if (cnt == CW'(WINDOW - 1)) state_nxt = SETTLE;
            SETTLE:  if (cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = run_last ? DONE : CLEAR;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort && state != IDLE) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            k                 <= '0;
            seed_q            <= '0;
            resp_sync         <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.resp_word     <= '0;
            bus.puf_enable    <= 1'b0;
            bus.puf_challenge <= '0;
`ifdef PUF_RO_VOTE_EN
            vote              <= '0;
            ones              <= '0;
`endif
        end else begin
            state     <= state_nxt;
            resp_sync <= {resp_sync[0], bus.puf_response};
            cnt       <= (state_nxt != state || state == IDLE) ? '0 : cnt + CW'(1);
            // Outputs registered from next state so they line up with the state register
            bus.busy       <= (state_nxt != IDLE) && (state_nxt != DONE);
            bus.done       <= (state_nxt == DONE);
            bus.puf_enable <= (state_nxt == RUN) || (state_nxt == SETTLE);
            if (state == CLEAR) bus.puf_challenge <= {hi, lo};
            if (accept) begin
                seed_q        <= bus.seed;
                k             <= '0;
                bus.resp_word <= '0;
`ifdef PUF_RO_VOTE_EN
                vote          <= '0;
                ones          <= '0;
`endif
            end
            if (state == SAMPLE && !bus.abort) begin
`ifdef PUF_RO_VOTE_EN
                if (!bit_done) begin
                    vote <= vote + 2'd1;
                    ones <= ones + {1'b0, resp_sync[1]};
                end else begin
                    bus.resp_word[k] <= ones[1] | (ones[0] & resp_sync[1]);
                    vote             <= '0;
                    ones             <= '0;
                    if (!run_last) k <= k + KW'(1);
                end
`else
                bus.resp_word[k] <= resp_sync[1];
                if (!run_last) k <= k + KW'(1);
`endif
            end
        end
    end
endmodule

// File: tb/tb_puf_ro_sequencer.sv
// Directed bench for puf_ro_sequencer with a behavioural PUF model and scoreboard queues.
module tb_puf_ro_sequencer;
    localparam int SIZE = 8, RESP_BITS = 4, WINDOW = 16, CLR = 4, SET = 4;
    localparam int P = CLR + WINDOW + SET + 1;
`ifdef PUF_RO_VOTE_EN
    localparam int PASSES = 3;
`else
    localparam int PASSES = 1;
`endif
    localparam int RUN_CYC = RESP_BITS * P * PASSES;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    puf_ro_sequencer_if #(.SIZE(SIZE), .RESP_BITS(RESP_BITS)) bus ();

    puf_ro_sequencer #(
        .SIZE(SIZE), .RESP_BITS(RESP_BITS), .WINDOW(WINDOW),
        .CLEAR_CYCLES(CLR), .SETTLE_CYCLES(SET)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_vec = 0, n_err = 0;
    int cyc = 0, start_cyc = 0, busy_start = 0, done_cnt = 0, en_rises = 0, meas = 0;
    logic en_prev = 1'b0, busy_prev = 1'b0, use_pattern = 1'b0;
    logic [SIZE-1:0] chal_held = '0, hot = '0;
    logic [0:11] pat = 12'b101_001_000_110;
    logic [SIZE-1:0]      chal_q[$];
    logic [RESP_BITS-1:0] resp_q[$];

    function automatic logic [7:0] chal_model(input logic [7:0] s, input int k);
        logic [3:0] l, h;
        l = s[3:0] + 4'(k);
        h = s[7:4] + 4'(3 * k);
        if (h == l) h = h + 4'd1;
        return {h, l};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.puf_enable && !en_prev) begin
            en_rises++;
            if (chal_q.size() == 0) check("chal_unexpected", {56'd0, bus.puf_challenge}, 64'hdead);
            else check("challenge", {56'd0, bus.puf_challenge}, {56'd0, chal_q.pop_front()});
            check("hi_ne_lo", 64'(bus.puf_challenge[7:4] != bus.puf_challenge[3:0]), 64'd1);
            bus.puf_response = use_pattern ? (meas < 12 ? pat[meas] : 1'b0)
                                           : (bus.puf_challenge == hot);
            meas++;
            chal_held = bus.puf_challenge;
        end else if (bus.puf_enable) begin
            check("chal_stable", {56'd0, bus.puf_challenge}, {56'd0, chal_held});
        end
        if (bus.busy && !busy_prev) busy_start = cyc;
        if (!bus.busy && busy_prev && bus.done) check("busy_len", 64'(cyc - busy_start), 64'(RUN_CYC));
        if (bus.done) begin
            done_cnt++;
            check("latency", 64'(cyc - start_cyc), 64'(RUN_CYC + 1));
            if (resp_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
            else check("resp_word", {60'd0, bus.resp_word}, {60'd0, resp_q.pop_front()});
        end
        en_prev   = bus.puf_enable;
        busy_prev = bus.busy;
    endtask

    task automatic launch(input logic [7:0] s);
        logic [RESP_BITS-1:0] e;
        int ones;
        for (int k = 0; k < RESP_BITS; k++) begin
            ones = 0;
            for (int p = 0; p < PASSES; p++) begin
                chal_q.push_back(chal_model(s, k));
                ones += use_pattern ? int'(pat[k * PASSES + p]) : int'(chal_model(s, k) == hot);
            end
            e[k] = (ones * 2 > PASSES);
        end
        resp_q.push_back(e);
        start_cyc = cyc;
        bus.seed  = s;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        check("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.seed = '0;
        bus.puf_response = 1'b0;
        repeat (3) step();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_resp", {60'd0, bus.resp_word}, 64'd0);
        check("rst_en", 64'(bus.puf_enable), 64'd0);
        check("rst_chal", {56'd0, bus.puf_challenge}, 64'd0);
        rst_n = 1'b1;

        // Idle: enable must never rise
        repeat (50) step();
        check("idle_no_enable", 64'(en_rises), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Seed 21: challenges 21,52,83,B4; only 52 answers 1
        hot = 8'h52;
        launch(8'h21);
        wait_done(RUN_CYC + 50);
        repeat (3) step();

        // Seed 00: k=0 collides, challenge becomes 10
        hot = 8'h31;
        launch(8'h00);
        wait_done(RUN_CYC + 50);
        repeat (3) step();

        // Abort during RUN of k=2, then a fresh run one cycle later
        hot = 8'h52;
        d0 = done_cnt;
        launch(8'h21);
        repeat (2 * P * PASSES + CLR + 4) step();
        check("en_in_run", 64'(bus.puf_enable), 64'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_en", 64'(bus.puf_enable), 64'd0);
        check("abort_partial", {60'd0, bus.resp_word}, 64'h2);
        chal_q.delete();
        void'(resp_q.pop_back());
        step();
        hot = 8'h83;
        launch(8'h21);
        wait_done(RUN_CYC + 50);
        check("abort_one_done", 64'(done_cnt - d0), 64'd1);
        repeat (3) step();

        // Start held every cycle during a run: exactly one Done
        hot = chal_model(8'h5A, 3);
        d0 = done_cnt;
        launch(8'h5A);
        for (int i = 0; i < RUN_CYC + 50 && done_cnt == d0; i++) begin
            bus.start = 1'b1;
            step();
        end
        bus.start = 1'b0;
        repeat (20) step();
        check("single_done", 64'(done_cnt - d0), 64'd1);
        check("idle_after", 64'(bus.busy), 64'd0);

        // Per-pass response pattern (majority when voting)
        use_pattern = 1'b1;
        meas = 0;
        launch(8'h10);
        wait_done(RUN_CYC + 50);
        repeat (3) step();
        check("tail_queue", 64'(chal_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
